// File: rtl/conv_pkg.sv
// Shared definitions for the conv layer engines: FSM states, default widths
// and the output ReLU/saturation stage.
package conv_pkg;

  localparam int DW_DEF    = 16;
  localparam int ACC_W_DEF = 40;
  localparam int FRAC_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REDUCE = 2'd2,
    OUT    = 2'd3
  } state_e;

  // Negative sums clamp to 0; positive sums drop FRAC bits and clamp to the
  // largest DW-bit signed value. The caller keeps the low DW bits.
  function automatic logic [63:0] sat_relu(input logic signed [63:0] sum,
                                           input int dw, input int frac);
    logic signed [63:0] sh;
    logic signed [63:0] mx;
    sh = sum >>> frac;
    mx = (64'sd1 <<< (dw - 1)) - 64'sd1;
    if (sum < 0)   return '0;
    if (sh > mx)   return mx;
    return sh;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane; clear beats enable, accumulator wraps.
module mac_lane #(
  parameter int DW    = 16,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    pixel,
  input  logic signed [DW-1:0]    kernel,
  output logic        [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic        [ACC_W-1:0] acc_q;

  assign prod = pixel * kernel;
  assign acc  = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  end

endmodule

// File: rtl/conv_volume_engine.sv
// Multi-channel convolution window engine: CH MAC lanes, lane reduction with
// bias, then ReLU/saturation presented on a valid/ready output.
module conv_volume_engine
  import conv_pkg::*;
#(
  parameter int CH    = 3,
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int TAPS  = 9,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] pixel_in,
  input  logic [CH*DW-1:0] kernel_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    conv_out,
  output logic             busy
);

  localparam int SW = ACC_W + $clog2(CH) + 1;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_e                  state_q, state_d;
  logic [TW-1:0]           tap_q, tap_d;
  logic [DW-1:0]           bias_q;
  logic signed [SW-1:0]    sum_q, sum_d;
  logic [CH-1:0][ACC_W-1:0] acc;
  logic                    beat;

  // start always wins over a beat in the same cycle
  assign in_ready  = (state_q == ACCUM) && !start;
  assign beat      = in_ready && in_valid;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign conv_out  = DW'(sat_relu(64'(sum_q), DW, FRAC));

  for (genvar g = 0; g < CH; g++) begin : g_lane
    mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (start),
      .en     (beat),
      .pixel  (pixel_in[g*DW +: DW]),
      .kernel (kernel_in[g*DW +: DW]),
      .acc    (acc[g])
    );
  end

  always_comb begin
    sum_d = {{(SW-DW){bias_q[DW-1]}}, bias_q} <<< FRAC;
    for (int c = 0; c < CH; c++)
      sum_d = sum_d + {{(SW-ACC_W){acc[c][ACC_W-1]}}, acc[c]};
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    if (start) begin
      state_d = ACCUM;
      tap_d   = '0;
    end else begin
      case (state_q)
        ACCUM: if (beat) begin
          if (tap_q == TW'(TAPS-1)) begin
            state_d = REDUCE;
            tap_d   = '0;
          end else begin
            tap_d = tap_q + TW'(1);
          end
        end
        REDUCE:  state_d = OUT;
        OUT:     if (out_ready) state_d = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      bias_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      if (start) bias_q <= bias;
      if (state_q == REDUCE && !start) sum_q <= sum_d;
    end
  end

endmodule

// File: tb/tb_conv_volume_engine.sv
// Directed bench for conv_volume_engine with hand-computed window results.
module tb_conv_volume_engine;
  localparam int CH = 3;
  localparam int DW = 16;
  localparam logic [CH*DW-1:0] U   = {CH{16'h0100}};
  localparam logic [CH*DW-1:0] NEG = {CH{16'hFF00}};
  localparam logic [CH*DW-1:0] MX  = {CH{16'h7FFF}};

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic             in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0]    bias = '0;
  logic [CH*DW-1:0] pixel_in = '0, kernel_in = '0;
  logic             in_ready, out_valid, busy;
  logic [DW-1:0]    conv_out;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  conv_volume_engine #(.CH(CH), .DW(DW), .ACC_W(40), .TAPS(9), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready),
    .pixel_in(pixel_in), .kernel_in(kernel_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .conv_out(conv_out), .busy(busy)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [DW-1:0] b);
    start = 1'b1; bias = b;
    tick();
    start = 1'b0;
  endtask

  // Offer beats until n have transferred; returns just after the last edge.
  task automatic feed(input logic [CH*DW-1:0] p, input logic [CH*DW-1:0] k,
                      input int n, input bit toggle);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 200) begin
      in_valid  = toggle ? ~cyc[0] : 1'b1;
      pixel_in  = p;
      kernel_in = k;
      #1;
      if (in_valid && in_ready) got++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL feed_beats got=%0d want=%0d", got, n);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000", {out_valid, in_ready, busy});
    end
    checks++;
    if (conv_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_conv_out got=%h want=0000", conv_out);
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_unity();
    start = 1'b1; bias = '0; in_valid = 1'b1; pixel_in = U; kernel_in = U;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL unity_start_ready got=%b want=0", in_ready);
    end
    tick();
    start = 1'b0;
    feed(U, U, 9, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL unity_lat_t1 got=%b want=0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || conv_out !== 16'h1B00) begin
      failures++;
      $display("FAIL unity_result valid=%b out=%h want 1/1b00", out_valid, conv_out);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL unity_handshake got=%b want=00", {out_valid, busy});
    end
  endtask

  task automatic test_negative();
    do_start(16'h0000);
    feed(U, NEG, 9, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || conv_out !== 16'h0000) begin
      failures++;
      $display("FAIL relu_result valid=%b out=%h want 1/0000", out_valid, conv_out);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_start(16'h7FFF);
    feed(MX, MX, 9, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || conv_out !== 16'h7FFF) begin
      failures++;
      $display("FAIL sat_result valid=%b out=%h want 1/7fff", out_valid, conv_out);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  // lane0 only: 9 * 1.5 * 1.0 = 13.5, bias -1/256 -> 0x0D7F after truncation
  task automatic test_mixed();
    do_start(16'hFFFF);
    feed({16'h0000, 16'h0000, 16'h0180}, U, 9, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || conv_out !== 16'h0D7F) begin
      failures++;
      $display("FAIL mixed_result valid=%b out=%h want 1/0d7f", out_valid, conv_out);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_abort();
    do_start(16'h1234);
    feed({CH{16'h7777}}, {CH{16'h5555}}, 4, 1'b0);
    start = 1'b1; bias = 16'h0200; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL abort_start_priority got=%b want=0", in_ready);
    end
    tick();
    start = 1'b0; in_valid = 1'b0;
    feed(U, U, 9, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || conv_out !== 16'h1D00) begin
      failures++;
      $display("FAIL abort_result valid=%b out=%h want 1/1d00", out_valid, conv_out);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_start(16'h0000);
    feed(U, U, 9, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b101 || conv_out !== 16'h1B00) begin
        failures++;
        $display("FAIL hold_cycle%0d v/r/b=%b out=%h want 101/1b00",
                 i, {out_valid, in_ready, busy}, conv_out);
      end
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b00 || conv_out !== 16'h1B00) begin
      failures++;
      $display("FAIL hold_release v/b=%b out=%h want 00/1b00", {out_valid, busy}, conv_out);
    end
  endtask

  task automatic test_out_abort();
    do_start(16'h0000);
    feed(U, U, 9, 1'b0);
    tick();
    start = 1'b1; out_ready = 1'b1; bias = '0;
    tick();
    start = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b011) begin
      failures++;
      $display("FAIL outabort_state got=%b want=011", {out_valid, in_ready, busy});
    end
    feed(U, {CH{16'h0200}}, 9, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || conv_out !== 16'h3600) begin
      failures++;
      $display("FAIL outabort_result valid=%b out=%h want 1/3600", out_valid, conv_out);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_start(16'h0000);
    feed(U, U, 4, 1'b0);
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b000) begin
      failures++;
      $display("FAIL midreset_flags got=%b want=000", {out_valid, in_ready, busy});
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    do_start(16'h0000);
    feed(U, U, 9, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || conv_out !== 16'h1B00) begin
      failures++;
      $display("FAIL midreset_result valid=%b out=%h want 1/1b00", out_valid, conv_out);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unity();
    test_negative();
    test_saturation();
    test_mixed();
    test_abort();
    test_backpressure();
    test_out_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_volume_engine.md
Name: conv_volume_engine

Overview:
- Parametrised multi-channel 3D convolution engine: CH parallel signed MAC lanes.
- Each lane accumulates TAPS pixel×kernel products of one window; lane results are summed by a registered adder tree.
- Bias add, ReLU, fixed-point rescale and saturation follow; one result per window is presented on a valid/ready output.
- Sits between the line-buffer/window feeder and the feature-map writer in each conv layer wrapper.

Parameters:
- CH, 3, number of input channels (MAC lanes).
- DW, 16, pixel/kernel/bias/output width, signed two's complement.
- ACC_W, 40, per-lane accumulator width.
- TAPS, 9, products accumulated per lane per window (3x3 kernel).
- FRAC, 8, fractional bits; the output takes sum bits [FRAC+DW-1:FRAC].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse: begin a new window; clears lanes and samples bias.
- bias  in  DW  signed bias in the same Q format as the output; sampled on start.
- in_valid  in  1  pixel/kernel beat valid.
- in_ready  out  1  engine accepts a beat.
- pixel_in  in  CH*DW  lane c occupies bits [c*DW +: DW].
- kernel_in  in  CH*DW  same packing as pixel_in.
- out_valid  out  1  conv_out holds a result.
- out_ready  in  1  downstream accepts the result.
- conv_out  out  DW  ReLU'd, saturated result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; tap counter, accumulators, bias register, sum register and conv_out are 0; in_valid-side in_ready=0; out_valid=0; busy=0.
- FSM states: IDLE, ACCUM, REDUCE, OUT.
- IDLE: start → ACCUM next cycle; lanes cleared; bias latched.
- ACCUM:
  - in_ready=1. A beat transfers on in_valid&&in_ready.
  - Per transfer, each lane does acc <= acc + sext(pixel*kernel); the product is signed 2*DW bits, sign-extended to ACC_W. The accumulator wraps modulo 2^ACC_W, with no overflow detection.
  - The tap counter increments per transfer. On the transfer with tap==TAPS-1, go to REDUCE.
  - in_valid low stalls indefinitely; there is no timeout.
- REDUCE (1 cycle):
  - in_ready=0.
  - sum = Σ lanes (sign-extended to ACC_W+clog2(CH)+1, so no overflow) + (sext(bias) << FRAC).
  - The result is registered; state → OUT.
- OUT:
  - out_valid=1; conv_out is registered and stable until the handshake.
  - conv_out = 0 if sum<0.
  - Otherwise conv_out = 2^(DW-1)-1 if (sum>>FRAC) > 2^(DW-1)-1.
  - Otherwise conv_out = sum[FRAC+DW-1:FRAC].
  - out_valid&&out_ready → IDLE next cycle, out_valid=0. conv_out keeps its last value.
- Latency: the last tap is accepted at cycle t; out_valid rises at t+2. Peak throughput is one window per TAPS+3 cycles.
- start outside IDLE aborts the current window:
  - Lanes are cleared, the tap counter is set to 0 and bias is re-latched.
  - out_valid drops next cycle; state → ACCUM.
  - start has priority over a simultaneous beat, which is not accepted (in_ready is forced 0 that cycle).
  - start in OUT together with out_ready: the result is dropped, not transferred. The restart wins.
- start in IDLE with in_valid high: in_ready=0 that cycle; the first beat is taken from the next cycle.
- TAPS=1 is legal: ACCUM → REDUCE after a single beat.

Decomposition:
- Package conv_pkg:
  - FSM state enum (IDLE/ACCUM/REDUCE/OUT).
  - Default DW/ACC_W/FRAC constants.
  - Saturation/ReLU function sat_relu(sum) shared with other conv wrappers.
- Sub-module mac_lane (clk, rst, clr, en, pixel, kernel, acc): one signed MAC with synchronous clear and enable. It is instantiated CH times through a generate loop.
- Adder tree, FSM and output stage are in the top module.

Test Plan:
- Unity window: CH=3, TAPS=9, FRAC=8, bias=0, all pixels=kernels=0x0100 for 9 beats → out_valid 2 cycles after beat 9; conv_out=0x1B00 (27.0).
- Negative/ReLU: same window with kernels=0xFF00 → sum=-0x1B0000; conv_out=0x0000.
- Saturation: pixels=kernels=0x7FFF, bias=0x7FFF → conv_out=0x7FFF.
- Bias and abort: 4 beats of garbage, then start with bias=0x0200, then the unity window → conv_out=0x1D00. Garbage contributions are absent.
- Backpressure and stalls:
  - in_valid toggled 1-0-1 per cycle → window completes after 9 accepted beats.
  - out_ready held low 5 cycles → conv_out and out_valid stable, in_ready=0, busy=1.
  - out_ready then asserted → IDLE next cycle.
- Reset mid-ACCUM: assert rst asynchronously at beat 5 → out_valid=0, in_ready=0, busy=0 immediately. A following unity window yields 0x1B00.
